alu_entry_controller: RTL
=========================

ALU_ENTRY_CONTROLLER -- requirements
Module: alu_entry_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd1_000_000, number of stable clock cycles before a button level is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd1000, maximum wait for alu_done before an error is declared.
REQ-003 Parameter BLINK_BIT, default 24, refresh-counter bit that sets the blink rate.
REQ-004 clk  in  1  single system clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sw  in  4  operand or opcode value from the slide switches.
REQ-007 btn_next  in  1  raw, asynchronous "enter/advance" push button.
REQ-008 btn_clear  in  1  raw, asynchronous "clear" push button.
REQ-009 alu_result  in  4  ALU result.
REQ-010 alu_done  in  1  ALU completion strobe.
REQ-011 ALU_src1, ALU_src2  out  4 each  latched operands, driving both the ALU and the display.
REQ-012 alu_op  out  3  latched opcode.
REQ-013 alu_start  out  1  one-cycle start pulse to the ALU.
REQ-014 ALU_out  out  4  latched result for the display.
REQ-015 digit_en  out  4  per-digit enable for the display, bit3 = src1, bit2 = src2, bit0 = out, bit1 always 0.
REQ-016 error  out  1  sticky ALU-timeout flag.
REQ-017 state_dbg  out  3  current state encoding.

Function
REQ-018 Each button passes through a two-flop synchronizer followed by a debounce counter; a new level is accepted only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-019 Each accepted 0->1 transition produces exactly one single-cycle press pulse; holding the button produces no repeat pulse.
REQ-020 The FSM states, with encodings, are S_SRC1=0, S_SRC2=1, S_OP=2, S_EXEC=3, S_WAIT=4, S_SHOW=5; codes 6 and 7 go to S_SRC1.
REQ-021 In S_SRC1, ALU_src1 follows sw live; a next-press freezes the current sw into ALU_src1 and moves to S_SRC2.
REQ-022 In S_SRC2, ALU_src2 follows sw live; a next-press freezes it and moves to S_OP.
REQ-023 In S_OP, a next-press latches sw[2:0] into alu_op and moves to S_EXEC.
REQ-024 S_EXEC lasts exactly one cycle, asserts alu_start=1 and moves to S_WAIT; alu_start is 0 in every other state.
REQ-025 In S_WAIT, alu_done=1 latches alu_result into ALU_out and moves to S_SHOW in the same edge; alu_done is ignored in all other states.
REQ-026 In S_WAIT, a wait counter that reaches TIMEOUT_CYCLES-1 without alu_done sets ALU_out=4'hF and error=1, then moves to S_SHOW.
REQ-027 If alu_done=1 in the same cycle as the timeout, alu_done wins and error stays unchanged.
REQ-028 In S_SHOW, a next-press clears ALU_src1, ALU_src2, ALU_out and alu_op to 0, leaves error unchanged, and moves to S_SRC1.
REQ-029 A clear-press in any state clears ALU_src1, ALU_src2, ALU_out, alu_op, error and the wait counter, and moves to S_SRC1.
REQ-030 When next-press and clear-press occur in the same cycle, clear-press wins.
REQ-031 digit_en blinks the field being edited: the src1 bit in S_SRC1 and the src2 bit in S_SRC2 equal the free-running counter bit BLINK_BIT.
REQ-032 digit_en holds fields already entered at steady 1, holds fields not yet entered at 0, and drives 4'b1101 in S_SHOW.
REQ-033 During S_OP, S_EXEC and S_WAIT, digit_en is 4'b1100.

Reset
REQ-034 Reset wins over all inputs and forces state=S_SRC1, all operand, result and opcode registers to 0, alu_start=0, error=0, and the debounce, wait and blink counters to 0.
REQ-035 Reset forces the synchronizer and debounced button levels to 0, so a button held through reset produces no press until it is released and pressed again.
REQ-036 Reset asserted during S_WAIT discards any subsequent alu_done.

Structure
REQ-037 A shared package holds the state typedef (REQ-020 encodings), the opcode width constant (3), and the digit_en pattern constants.
REQ-038 Sub-module button_debouncer (synchronizer + debounce counter + edge pulse) is instantiated once per button.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8)
REQ-039 sw=3 then next, sw=5 then next, sw=2 then next, alu_done two cycles after alu_start with alu_result=8 -> one alu_start pulse, ALU_src1=3, ALU_src2=5, alu_op=2, ALU_out=8, state=S_SHOW, error=0.
REQ-040 btn_next bouncing 1,0,1 over 3 cycles, then held for 20 cycles -> exactly one press and one state advance.
REQ-041 No alu_done after alu_start -> S_SHOW reached 8 cycles after alu_start, ALU_out=4'hF, error=1; a following clear -> error=0, state=S_SRC1.
REQ-042 alu_done arriving on the timeout cycle with alu_result=6 -> ALU_out=6, error=0.
REQ-043 Next and clear pressed in the same cycle while in S_SRC2 -> state=S_SRC1 and all registers 0.
REQ-044 Reset asserted in S_WAIT with alu_done=1 on the following cycle -> state=S_SRC1 and ALU_out=0.

Source files
------------

// File: rtl/alu_entry_controller_pkg.sv
// Shared state encodings, opcode width and display-enable patterns for the
// operand/opcode entry controller.
package alu_entry_controller_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_SRC1 = 3'd0;
    localparam state_t S_SRC2 = 3'd1;
    localparam state_t S_OP   = 3'd2;
    localparam state_t S_EXEC = 3'd3;
    localparam state_t S_WAIT = 3'd4;
    localparam state_t S_SHOW = 3'd5;

    localparam int OP_W  = 3;
    localparam int DEB_W = 20;

    // digit_en bit3 = src1, bit2 = src2, bit0 = result
    localparam logic [3:0] DIG_NONE = 4'b0000;
    localparam logic [3:0] DIG_SRC1 = 4'b1000;
    localparam logic [3:0] DIG_OPS  = 4'b1100;
    localparam logic [3:0] DIG_SHOW = 4'b1101;

endpackage

// File: rtl/alu_entry_controller_button_debouncer.sv
// Two-flop synchronizer, debounce counter and single-cycle press pulse for
// one raw push button.
module button_debouncer
    import alu_entry_controller_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic             armed;
    logic [DEB_W-1:0] cnt;

    // Until a stable low is seen after reset, a held button cannot fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            armed  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (!armed) begin
                if (sync_b) begin
                    cnt <= '0;
                end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            end else if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
                level <= sync_b;
                press <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/alu_entry_controller.sv
// Button-driven entry of two operands and an opcode, ALU handshake with
// timeout, and blinking per-digit display enables.
module alu_entry_controller
    import alu_entry_controller_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter logic [15:0] TIMEOUT_CYCLES  = 16'd1000,
    parameter int          BLINK_BIT       = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      sw,
    input  logic            btn_next,
    input  logic            btn_clear,
    input  logic [3:0]      alu_result,
    input  logic            alu_done,
    output logic [3:0]      ALU_src1,
    output logic [3:0]      ALU_src2,
    output logic [OP_W-1:0] alu_op,
    output logic            alu_start,
    output logic [3:0]      ALU_out,
    output logic [3:0]      digit_en,
    output logic            error,
    output logic [2:0]      state_dbg
);

    localparam logic [BLINK_BIT:0] BLINK_ONE = {{BLINK_BIT{1'b0}}, 1'b1};

    logic               next_press;
    logic               clear_press;
    state_t             state;
    logic [15:0]        wait_cnt;
    logic [BLINK_BIT:0] blink_cnt;
    logic               blink;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_next),
        .press (next_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clear),
        .press (clear_press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_SRC1;
            ALU_src1  <= '0;
            ALU_src2  <= '0;
            alu_op    <= '0;
            ALU_out   <= '0;
            error     <= 1'b0;
            wait_cnt  <= '0;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_ONE;
            if (clear_press) begin
                state    <= S_SRC1;
                ALU_src1 <= '0;
                ALU_src2 <= '0;
                alu_op   <= '0;
                ALU_out  <= '0;
                error    <= 1'b0;
                wait_cnt <= '0;
            end else begin
                case (state)
                    S_SRC1: begin
                        ALU_src1 <= sw;
                        if (next_press) state <= S_SRC2;
                    end
                    S_SRC2: begin
                        ALU_src2 <= sw;
                        if (next_press) state <= S_OP;
                    end
                    S_OP: begin
                        if (next_press) begin
                            alu_op <= sw[OP_W-1:0];
                            state  <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                    // A done strobe on the timeout cycle still delivers its result.
                    S_WAIT: begin
                        if (alu_done) begin
                            ALU_out <= alu_result;
                            state   <= S_SHOW;
                        end else if (wait_cnt == TIMEOUT_CYCLES - 16'd1) begin
                            ALU_out <= 4'hF;
                            error   <= 1'b1;
                            state   <= S_SHOW;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                    S_SHOW: begin
                        if (next_press) begin
                            ALU_src1 <= '0;
                            ALU_src2 <= '0;
                            alu_op   <= '0;
                            ALU_out  <= '0;
                            state    <= S_SRC1;
                        end
                    end
                    default: state <= S_SRC1;
                endcase
            end
        end
    end

    assign blink     = blink_cnt[BLINK_BIT];
    assign alu_start = (state == S_EXEC);
    assign state_dbg = state;

    always_comb begin
        digit_en = DIG_NONE;
        case (state)
            S_SRC1:               digit_en = {blink, 3'b000};
            S_SRC2:               digit_en = DIG_SRC1 | {1'b0, blink, 2'b00};
            S_OP, S_EXEC, S_WAIT: digit_en = DIG_OPS;
            S_SHOW:               digit_en = DIG_SHOW;
            default:              digit_en = DIG_NONE;
        endcase
    end

endmodule
